// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl_pkg
//  Description : Shared register offsets, state encoding and constants for
//                the memory-mapped interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    // Register offsets relative to the block base address
    localparam logic [1:0] OFF_MASK   = 2'd0;
    localparam logic [1:0] OFF_ACTIVE = 2'd1;
    localparam logic [1:0] OFF_PEND   = 2'd2;
    localparam logic [1:0] OFF_EOI    = 2'd3;

    // ACTIVE value reported when the CPU acknowledges with nothing enabled
    localparam logic [7:0] SPURIOUS_ID = 8'h0F;

    // Raise/ack handshake sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAISE   = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // ACTIVE register encoding of a real (non-spurious) source
    function automatic logic [7:0] active_word(input logic [2:0] id);
        return {1'b1, 4'b0000, id};
    endfunction

endpackage : irq_ctrl_pkg
`default_nettype wire

// File: rtl/irq_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : irq_priority_encoder
//  Description : Combinational fixed-priority encoder; the lowest set index
//                of the enabled vector wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_priority_encoder #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] i_enabled,
    output logic               o_valid,
    output logic [2:0]         o_id
);

    // Scan from the top down so the lowest set index is the last to assign
    always_comb begin
        o_valid = |i_enabled;
        o_id    = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_enabled[i]) begin
                o_id = 3'(i);
            end
        end
    end

endmodule : irq_priority_encoder
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : irq_controller
//  Description : Memory-mapped interrupt controller on the 8-bit CPU bus.
//                Latches peripheral requests as pending, masks them, picks
//                one by fixed priority and runs a raise/ack/EOI handshake
//                with the CPU on a single interrupt line.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] BASE_ADDR = 8'hC0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [7:0]         BUS_ADDR,
    inout  wire  [7:0]         BUS_DATA,
    input  logic               BUS_WE,
    input  logic [NUM_SRC-1:0] SRC_RAISE,
    output logic [NUM_SRC-1:0] SRC_ACK,
    output logic               CPU_IRQ_RAISE,
    input  logic               CPU_IRQ_ACK
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_src_ack;
    logic [7:0]         r_active;
    logic [7:0]         r_rd_data;
    logic               r_rd_oe;
    irq_state_t         r_state;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [7:0]         w_offset;
    logic               w_hit;
    logic [1:0]         w_off;
    logic               w_wr_mask;
    logic               w_wr_pend;
    logic               w_wr_eoi;
    logic               w_rd;
    logic [NUM_SRC-1:0] w_wdata;
    logic [7:0]         w_mask_word;
    logic [7:0]         w_pend_word;
    logic [7:0]         w_rd_mux;
    logic [NUM_SRC-1:0] w_enabled;
    logic               w_any;
    logic [2:0]         w_id;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_pend_nxt;
    irq_state_t         w_state_nxt;
    logic               w_irq_raise;
    logic               w_capture;
    logic               w_spurious;
    logic               w_eoi_clr;

    // Window decode: subtracting the base keeps it correct for unaligned bases
    assign w_offset  = BUS_ADDR - BASE_ADDR;
    assign w_hit     = (w_offset[7:2] == 6'd0);
    assign w_off     = w_offset[1:0];
    assign w_wr_mask = w_hit && BUS_WE && (w_off == OFF_MASK);
    assign w_wr_pend = w_hit && BUS_WE && (w_off == OFF_PEND);
    assign w_wr_eoi  = w_hit && BUS_WE && (w_off == OFF_EOI);
    assign w_rd      = w_hit && !BUS_WE;

    // Only the bits that map to real sources are writable
    assign w_wdata   = BUS_DATA[NUM_SRC-1:0];

    // Data bus is driven only in the cycle after a matching read
    assign BUS_DATA  = r_rd_oe ? r_rd_data : 8'hzz;

    // Arbitration
    assign w_enabled = r_pend & r_mask;

    irq_priority_encoder #(
        .NUM_SRC   (NUM_SRC)
    ) u_prio (
        .i_enabled (w_enabled),
        .o_valid   (w_any),
        .o_id      (w_id)
    );

    // Zero-extend source-wide registers onto the 8-bit bus
    always_comb begin
        w_mask_word                = 8'h00;
        w_pend_word                = 8'h00;
        w_mask_word[NUM_SRC-1:0]   = r_mask;
        w_pend_word[NUM_SRC-1:0]   = r_pend;
    end

    // Read data selection for the registered read response
    always_comb begin
        w_rd_mux = 8'h00;
        case (w_off)
            OFF_MASK:   w_rd_mux = w_mask_word;
            OFF_ACTIVE: w_rd_mux = r_active;
            OFF_PEND:   w_rd_mux = w_pend_word;
            default:    w_rd_mux = 8'h00;
        endcase
    end

    // Handshake sequencer: next state and decoded actions
    always_comb begin
        w_state_nxt = r_state;
        w_irq_raise = 1'b0;
        w_capture   = 1'b0;
        w_spurious  = 1'b0;
        w_eoi_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = RAISE;
                end
            end
            RAISE: begin
                w_irq_raise = 1'b1;
                // An ack always moves on, even if the request vanished meanwhile
                if (CPU_IRQ_ACK) begin
                    w_capture   = w_any;
                    w_spurious  = !w_any;
                    w_state_nxt = SERVICE;
                end else if (!w_any) begin
                    w_state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (w_wr_eoi) begin
                    w_eoi_clr   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pending update: raises set, W1C and the serviced bit clear, set wins
    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ack_clr[i] = w_capture && (w_id == 3'(i));
        end
        w_w1c      = w_wr_pend ? w_wdata : '0;
        w_pend_nxt = (r_pend & ~w_w1c & ~w_ack_clr) | SRC_RAISE;
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mask, pending and per-source acknowledge registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_mask    <= '0;
            r_pend    <= '0;
            r_src_ack <= '0;
        end else begin
            if (w_wr_mask) begin
                r_mask <= w_wdata;
            end
            r_pend    <= w_pend_nxt;
            r_src_ack <= SRC_RAISE & ~r_src_ack;
        end
    end

    // ACTIVE register: loaded on CPU ack, cleared by EOI
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_active <= 8'h00;
        end else if (w_capture) begin
            r_active <= active_word(w_id);
        end else if (w_spurious) begin
            r_active <= SPURIOUS_ID;
        end else if (w_eoi_clr) begin
            r_active <= 8'h00;
        end
    end

    // Registered read response, RAM-like one-cycle latency
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rd_oe   <= 1'b0;
            r_rd_data <= 8'h00;
        end else begin
            r_rd_oe   <= w_rd;
            r_rd_data <= w_rd ? w_rd_mux : 8'h00;
        end
    end

    assign SRC_ACK       = r_src_ack;
    assign CPU_IRQ_RAISE = w_irq_raise;

endmodule : irq_controller
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_controller
//  Description : Self-checking bench for irq_controller. Read responses are
//                checked through an expected-value queue; the bus is pulled
//                up so an undriven bus reads 8'hFF.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_irq_controller;

    localparam logic [7:0] BASE      = 8'hC0;
    localparam logic [7:0] IDLE_ADDR = 8'h00;
    localparam logic [7:0] HIZ       = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bus_addr = IDLE_ADDR;
    logic       bus_we = 1'b0;
    logic [7:0] drv_data = 8'h00;
    logic       drv_oe = 1'b0;
    logic [3:0] src_raise = 4'h0;
    logic [3:0] src_ack;
    logic       cpu_irq_raise;
    logic       cpu_irq_ack = 1'b0;
    wire  [7:0] bus_data;

    logic       rd_issue = 1'b0;
    logic       rd_due = 1'b0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    assign bus_data = drv_oe ? drv_data : 8'hzz;

    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup (bus_data[i]);
    end

    irq_controller #(
        .NUM_SRC       (4),
        .BASE_ADDR     (BASE)
    ) dut (
        .CLK           (clk),
        .RST           (rst_n),
        .BUS_ADDR      (bus_addr),
        .BUS_DATA      (bus_data),
        .BUS_WE        (bus_we),
        .SRC_RAISE     (src_raise),
        .SRC_ACK       (src_ack),
        .CPU_IRQ_RAISE (cpu_irq_raise),
        .CPU_IRQ_ACK   (cpu_irq_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // A read address sampled at an edge produces data in the following cycle
    always @(posedge clk) rd_due <= rd_issue;

    // Response monitor: pop on a due read, otherwise the bus must be released
    always @(negedge clk) begin
        if (rd_due) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                check_eq(tag_q.pop_front(), bus_data, exp_q.pop_front());
            end
        end else if (!drv_oe) begin
            check_eq("bus_hiz", bus_data, HIZ);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [7:0] data);
        bus_addr = BASE + 8'(off);
        bus_we   = 1'b1;
        drv_data = data;
        drv_oe   = 1'b1;
        tick();
        bus_we   = 1'b0;
        drv_oe   = 1'b0;
        bus_addr = IDLE_ADDR;
    endtask

    task automatic bus_read(input logic [1:0] off, input logic [7:0] exp, input string tag);
        bus_addr = BASE + 8'(off);
        bus_we   = 1'b0;
        rd_issue = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        rd_issue = 1'b0;
        bus_addr = IDLE_ADDR;
        tick();
    endtask

    task automatic raise_sources(input logic [3:0] m, input string tag);
        src_raise = m;
        tick();
        check_eq({tag, "_ack"}, src_ack, m);
        check_eq({tag, "_irq_early"}, cpu_irq_raise, 1'b0);
        src_raise = 4'h0;
        tick();
        check_eq({tag, "_ack_end"}, src_ack, 4'h0);
    endtask

    task automatic cpu_ack();
        cpu_irq_ack = 1'b1;
        tick();
        cpu_irq_ack = 1'b0;
    endtask

    initial begin
        // 1. reset and single source
        #2;
        check_eq("rst_irq", cpu_irq_raise, 1'b0);
        check_eq("rst_ack", src_ack, 4'h0);
        check_eq("rst_bus", bus_data, HIZ);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        bus_read(2'd0, 8'h00, "rst_mask");
        bus_read(2'd1, 8'h00, "rst_active");
        bus_read(2'd2, 8'h00, "rst_pend");
        bus_write(2'd0, 8'h01);
        raise_sources(4'h1, "t1");
        check_eq("t1_irq", cpu_irq_raise, 1'b1);
        cpu_ack();
        check_eq("t1_irq_svc", cpu_irq_raise, 1'b0);
        bus_read(2'd1, 8'h80, "t1_active");
        bus_read(2'd2, 8'h00, "t1_pend");
        bus_write(2'd3, 8'h5A);
        bus_read(2'd1, 8'h00, "t1_active_eoi");
        check_eq("t1_idle", cpu_irq_raise, 1'b0);

        // 2. priority
        bus_write(2'd0, 8'h0F);
        raise_sources(4'hA, "t2");
        check_eq("t2_irq", cpu_irq_raise, 1'b1);
        cpu_ack();
        bus_read(2'd1, 8'h81, "t2_active1");
        bus_read(2'd2, 8'h08, "t2_pend1");
        bus_write(2'd3, 8'h00);
        check_eq("t2_irq_eoi", cpu_irq_raise, 1'b0);
        tick();
        check_eq("t2_irq_again", cpu_irq_raise, 1'b1);
        cpu_ack();
        bus_read(2'd1, 8'h83, "t2_active2");
        bus_read(2'd2, 8'h00, "t2_pend2");
        bus_write(2'd3, 8'h00);
        tick();
        check_eq("t2_idle", cpu_irq_raise, 1'b0);

        // 3. masking
        bus_write(2'd0, 8'h00);
        raise_sources(4'h4, "t3");
        check_eq("t3_masked", cpu_irq_raise, 1'b0);
        bus_read(2'd2, 8'h04, "t3_pend");
        check_eq("t3_still_masked", cpu_irq_raise, 1'b0);
        bus_write(2'd0, 8'h04);
        check_eq("t3_mask_edge", cpu_irq_raise, 1'b0);
        tick();
        check_eq("t3_unmasked", cpu_irq_raise, 1'b1);
        bus_write(2'd2, 8'h04);
        check_eq("t3_w1c_edge", cpu_irq_raise, 1'b1);
        tick();
        check_eq("t3_w1c_drop", cpu_irq_raise, 1'b0);
        bus_read(2'd2, 8'h00, "t3_pend_clr");

        // 4. spurious ack
        raise_sources(4'h4, "t4");
        check_eq("t4_irq", cpu_irq_raise, 1'b1);
        bus_write(2'd0, 8'h00);
        cpu_ack();
        check_eq("t4_irq_svc", cpu_irq_raise, 1'b0);
        bus_read(2'd1, 8'h0F, "t4_spurious");
        bus_read(2'd2, 8'h04, "t4_pend");
        bus_write(2'd3, 8'h00);
        bus_read(2'd1, 8'h00, "t4_active_eoi");
        check_eq("t4_idle", cpu_irq_raise, 1'b0);
        bus_write(2'd2, 8'h04);

        // 5. conflicts
        src_raise = 4'h1;
        bus_write(2'd2, 8'h01);
        check_eq("t5_ack", src_ack, 4'h1);
        src_raise = 4'h0;
        tick();
        bus_read(2'd2, 8'h01, "t5_set_wins");
        bus_write(2'd3, 8'h00);
        check_eq("t5_eoi_idle", cpu_irq_raise, 1'b0);
        bus_read(2'd1, 8'h00, "t5_active_idle");
        bus_write(2'd0, 8'h01);
        tick();
        check_eq("t5_irq", cpu_irq_raise, 1'b1);
        bus_write(2'd3, 8'h00);
        check_eq("t5_eoi_raise", cpu_irq_raise, 1'b1);
        cpu_ack();
        cpu_ack();
        bus_read(2'd1, 8'h80, "t5_ack_in_svc");
        bus_read(2'd0, 8'h01, "t5_mask_read");
        bus_write(2'd3, 8'h00);
        tick();
        check_eq("t5_idle", cpu_irq_raise, 1'b0);

        // 6. reset mid-operation
        bus_write(2'd0, 8'h0F);
        raise_sources(4'h7, "t6");
        check_eq("t6_irq", cpu_irq_raise, 1'b1);
        cpu_ack();
        bus_read(2'd2, 8'h06, "t6_pend");
        src_raise = 4'h8;
        tick();
        check_eq("t6_ack_pre", src_ack, 4'h8);
        #3;
        rst_n     = 1'b0;
        src_raise = 4'h0;
        #1;
        check_eq("t6_rst_irq", cpu_irq_raise, 1'b0);
        check_eq("t6_rst_ack", src_ack, 4'h0);
        check_eq("t6_rst_bus", bus_data, HIZ);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        bus_read(2'd0, 8'h00, "t6_mask");
        bus_read(2'd2, 8'h00, "t6_pend_rst");
        bus_read(2'd1, 8'h00, "t6_active_rst");
        check_eq("t6_idle", cpu_irq_raise, 1'b0);

        tick();
        check_eq("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_irq_controller
`default_nettype wire

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller on the shared 8-bit CPU bus.
- Collects up to NUM_SRC peripheral interrupt requests (Timer, IR transmitter, future peripherals) and latches them as pending. Masks them and selects one by fixed priority.
- Sequences a single raise/ack handshake on one CPU interrupt line. The ISR reads the active source ID and writes an end-of-interrupt (EOI) before the next interrupt is raised.

Parameters:
NUM_SRC, 4, number of peripheral sources (legal 1..8); source 0 has the highest priority.
BASE_ADDR, 8'hC0, bus base address; the block decodes BASE_ADDR..BASE_ADDR+3.

Ports:
CLK  in  1  system clock.
RST  in  1  reset, asynchronous, active-low.
BUS_ADDR  in  8  CPU address bus.
BUS_DATA  inout  8  CPU data bus; driven only during a read response, high-Z otherwise.
BUS_WE  in  1  bus write enable.
SRC_RAISE  in  NUM_SRC  peripheral requests; each is held high until its ack.
SRC_ACK  out  NUM_SRC  one-cycle acknowledge to each peripheral.
CPU_IRQ_RAISE  out  1  interrupt request to the CPU.
CPU_IRQ_ACK  in  1  one-cycle pulse from the CPU on ISR entry.

Behaviour:
- Reset (RST low, asynchronous): all outputs and registers clear to 0, BUS_DATA goes high-Z, and the state machine goes to IDLE.
- Register map:
  - +0 MASK: R/W, reset 8'h00; bit i = 1 enables source i.
  - +1 ACTIVE: RO; bit7 = valid, [2:0] = source ID; reads 8'h0F for a spurious interrupt.
  - +2 PENDING: R, write-1-to-clear.
  - +3 EOI: WO, data ignored.
  - Bits at or above NUM_SRC read 0; writes to them are ignored.
- Bus writes: take effect on the CLK edge where BUS_WE=1 and the address matches.
- Bus reads: when BUS_WE=0 and the address matches, read data and the output enable are registered. BUS_DATA is driven for exactly the following cycle (same timing as RAM).
- Source capture: each cycle, pending[i] is set when SRC_RAISE[i]=1. SRC_ACK[i] is registered as SRC_RAISE[i] & ~SRC_ACK[i], so the ack goes high 1 cycle after raise is sampled and does not repeat back-to-back.
- Pending set/clear conflict: if a raise and a W1C hit the same bit in the same cycle, set wins.
- enabled = pending & MASK; any = |enabled.
- State machine (2-bit, registered):
  - IDLE: CPU_IRQ_RAISE=0. Goes to RAISE when any=1.
  - RAISE: CPU_IRQ_RAISE=1.
    - On CPU_IRQ_ACK, capture the lowest-index enabled bit into ACTIVE as {1'b1,4'b0,id}, clear that pending bit, and go to SERVICE.
    - If CPU_IRQ_ACK arrives but any=0 in the same cycle, load ACTIVE=8'h0F and go to SERVICE.
    - If any falls to 0 without an ack (mask or W1C change), return to IDLE.
  - SERVICE: CPU_IRQ_RAISE=0. New requests keep latching into pending. A write to EOI clears ACTIVE to 8'h00 and goes to IDLE.
  - EOI writes in IDLE or RAISE are ignored. CPU_IRQ_ACK in IDLE or SERVICE is ignored.
- Latency:
  - SRC_RAISE high at edge n → pending at edge n+1 → CPU_IRQ_RAISE high after edge n+2.
  - After the EOI edge, the next raise appears 1 edge later if enabled pending bits remain.
- Simultaneous ack and source raise: the ack arbitrates over the pending value registered at that edge; the new raise becomes pending for the next round.

Decomposition:
- Package irq_ctrl_pkg holds:
  - register offsets: OFF_MASK=0, OFF_ACTIVE=1, OFF_PEND=2, OFF_EOI=3;
  - state encoding: IDLE=0, RAISE=1, SERVICE=2;
  - SPURIOUS_ID=8'h0F.
- One natural sub-module: irq_priority_encoder. It is combinational, takes the NUM_SRC enabled vector, and outputs a valid flag and a 3-bit lowest-index ID.

Test Plan:
1. Reset then single source: release RST; write MASK=8'h01; pulse SRC_RAISE[0] until ack.
   → SRC_ACK[0] is a one-cycle pulse; CPU_IRQ_RAISE high 2 cycles after raise.
   → After CPU_IRQ_ACK, reading +1 returns 8'h80; writing +3 returns to IDLE with ACTIVE=8'h00.
2. Priority: MASK=8'h0F; sources 1 and 3 raise in the same cycle.
   → First ACTIVE=8'h81 and PENDING=8'h08.
   → After EOI, raise reasserts; ACTIVE=8'h83; then PENDING=8'h00.
3. Masking: MASK=8'h00; source 2 raises.
   → PENDING=8'h04 and CPU_IRQ_RAISE stays 0.
   → Writing MASK=8'h04 raises the interrupt 1 cycle later.
   → In RAISE, writing PENDING W1C 8'h04 drops CPU_IRQ_RAISE and returns to IDLE.
4. Spurious: in RAISE, clear MASK and pulse CPU_IRQ_ACK in the same cycle.
   → ACTIVE reads 8'h0F; EOI returns to IDLE.
5. Conflicts: W1C of bit 0 in the same cycle as SRC_RAISE[0] → PENDING bit 0 stays 1.
   → EOI written in IDLE → no state change.
   → A read of +0 drives BUS_DATA only in the following cycle; high-Z otherwise.
6. Reset mid-operation: assert RST in SERVICE with PENDING=8'h06.
   → All outputs 0 and BUS_DATA high-Z immediately; after release, MASK and PENDING read 8'h00.
